// File: rtl/dense_pkg.sv
// Shared definitions for the dense layer: FSM encoding, width helpers, saturation helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dense_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    // Working width for the shift/bias/saturate path; wide enough for any sane N
    localparam int SAT_W = 128;

    // Saturation decision codes
    localparam logic [1:0] SAT_NONE = 2'b00;
    localparam logic [1:0] SAT_HI   = 2'b01;
    localparam logic [1:0] SAT_LO   = 2'b10;

    // Accumulator width: full product plus growth for NUM_INPUTS additions plus a guard bit
    function automatic int acc_width(input int n, input int num_inputs);
        return 2 * n + $clog2(num_inputs) + 1;
    endfunction

    // Beat counter width: must be able to hold NUM_INPUTS-1 (at least one bit)
    function automatic int cnt_width(input int num_inputs);
        return $clog2(num_inputs + 1);
    endfunction

    // Classifies an already shifted-and-biased value against the signed n-bit range
    function automatic logic [1:0] sat_code(input logic signed [SAT_W-1:0] v, input int n);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (n - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) begin
            return SAT_HI;
        end
        if (v < lo) begin
            return SAT_LO;
        end
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/dense_lane.sv
// One neuron lane: signed N x N multiply accumulated into a non-overflowing accumulator.
// Latency: o_acc_next is combinational (acc + product); accumulator updates on the beat edge.
// Backpressure: none; the parent enables the lane only on accepted beats.
module dense_lane #(
    parameter int N     = 16,
    parameter int ACC_W = 35
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_clear,
    input  logic                    i_en,
    input  logic signed [N-1:0]     i_data,
    input  logic signed [N-1:0]     i_weight,
    output logic signed [ACC_W-1:0] o_acc_next
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [2*N-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_acc_next;

    assign w_prod     = i_data * i_weight;
    assign w_acc_next = r_acc + {{(ACC_W - 2 * N){w_prod[2*N-1]}}, w_prod};
    assign o_acc_next = w_acc_next;

    // Accumulator: cleared at vector start, advanced only on accepted beats
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_next;
        end
    end

endmodule

// File: rtl/dense_layer.sv
// Fixed-point dense layer: NUM_OUTPUTS parallel MAC lanes, bias, saturate, optional ReLU.
// Latency: out_valid rises 1 cycle after the final accepted input beat.
// Backpressure: in_ready only in ACCUM; result held stable in OUTPUT until out_ready.
module dense_layer
    import dense_pkg::*;
#(
    parameter int N           = 16,
    parameter int Q           = 8,
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 4,
    parameter int RELU_EN     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_data,
    input  logic [NUM_OUTPUTS*N-1:0]   weight_flat,
    input  logic [NUM_OUTPUTS*N-1:0]   bias_flat,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_OUTPUTS*N-1:0]   out_data,
    output logic                       busy,
    output logic                       done
);

    localparam int ACC_W = acc_width(N, NUM_INPUTS);
    localparam int CNT_W = cnt_width(NUM_INPUTS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_done;
    logic [NUM_OUTPUTS*N-1:0] r_out;

    logic                     w_start;
    logic                     w_beat;
    logic                     w_last;
    logic                     w_accept_out;
    logic [NUM_OUTPUTS*N-1:0] w_res_flat;

    assign w_start      = (r_state == ST_IDLE) && start;
    assign w_beat       = (r_state == ST_ACCUM) && in_valid;
    assign w_last       = w_beat && (r_cnt == LAST_CNT);
    assign w_accept_out = (r_state == ST_OUTPUT) && out_ready;

    for (genvar j = 0; j < NUM_OUTPUTS; j++) begin : g_lane
        logic signed [ACC_W-1:0] w_acc_next;
        logic signed [ACC_W-1:0] w_shift;
        logic signed [SAT_W-1:0] w_sum;
        logic [1:0]              w_code;
        logic signed [N-1:0]     w_sat;

        dense_lane #(
            .N     (N),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .i_clear    (w_start),
            .i_en       (w_beat),
            .i_data     (in_data),
            .i_weight   (weight_flat[j*N +: N]),
            .o_acc_next (w_acc_next)
        );

        // Arithmetic shift floors toward -inf; bias is sign-extended before the add
        assign w_shift = w_acc_next >>> Q;
        assign w_sum   = {{(SAT_W - ACC_W){w_shift[ACC_W-1]}}, w_shift}
                       + {{(SAT_W - N){bias_flat[j*N+N-1]}}, bias_flat[j*N +: N]};
        assign w_code  = sat_code(w_sum, N);
        assign w_sat   = (w_code == SAT_HI) ? {1'b0, {(N - 1){1'b1}}} :
                         (w_code == SAT_LO) ? {1'b1, {(N - 1){1'b0}}} :
                                              w_sum[N-1:0];
        assign w_res_flat[j*N +: N] = ((RELU_EN != 0) && w_sat[N-1]) ? '0 : w_sat;
    end

    // Control FSM, beat counter, done pulse and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_out   <= '0;
        end else begin
            r_done <= w_accept_out;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ACCUM;
                        r_cnt   <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_last) begin
                        r_state <= ST_OUTPUT;
                        r_out   <= w_res_flat;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_OUTPUT);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign out_data  = r_out;

endmodule

// File: doc/dense_layer.md
DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning total fixed-point word width.
REQ-002 The block SHALL have parameter Q, default 8, meaning fractional bits.
REQ-003 The block SHALL have parameter NUM_INPUTS, default 4, meaning input vector length (>=1).
REQ-004 The block SHALL have parameter NUM_OUTPUTS, default 4, meaning neurons computed in parallel (>=1).
REQ-005 The block SHALL have parameter RELU_EN, default 1, meaning that ReLU is applied to outputs when 1.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit, which begins a new vector; it is sampled only in IDLE.
REQ-009 The block SHALL have port in_valid, input, 1 bit, meaning in_data and weight_flat are valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts an input beat.
REQ-011 The block SHALL have port in_data, input, N bits, one signed input element per beat.
REQ-012 The block SHALL have port weight_flat, input, NUM_OUTPUTS*N bits, signed weight for lane j at bits [j*N +: N], for the current element.
REQ-013 The block SHALL have port bias_flat, input, NUM_OUTPUTS*N bits, signed per-lane bias, sampled on the final input beat.
REQ-014 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds a result.
REQ-015 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-016 The block SHALL have port out_data, output, NUM_OUTPUTS*N bits, signed per-lane result in the same packing as weight_flat.
REQ-017 The block SHALL have port busy, output, 1 bit, which is high whenever state is not IDLE.
REQ-018 The block SHALL have port done, output, 1 bit, a one-cycle pulse on the result handshake.

Function
REQ-019 The FSM SHALL have states IDLE, ACCUM and OUTPUT.
- IDLE->ACCUM on start.
- ACCUM->OUTPUT on the NUM_INPUTS-th accepted beat.
- OUTPUT->IDLE on out_valid&&out_ready.
REQ-020 On IDLE->ACCUM, all lane accumulators and the beat counter SHALL clear to 0.
REQ-021 in_ready SHALL equal (state==ACCUM); a beat SHALL be accepted only on the cycle where in_valid&&in_ready, and gaps in in_valid SHALL stall without corrupting state.
REQ-022 Each accepted beat SHALL add the full 2N-bit signed product in_data*weight_j to accumulator j.
REQ-023 Each accumulator SHALL be 2N+clog2(NUM_INPUTS)+1 bits wide so that it never overflows internally.
REQ-024 On the final beat, out_data lane j SHALL register sat((acc_j_next >>> Q) + bias_j).
- The shift is arithmetic, truncating toward negative infinity.
- sat clamps to [-2^(N-1), 2^(N-1)-1].
- The sum is sign-extended before the add.
- When RELU_EN=1, negative results are replaced by 0 after saturation.
REQ-025 out_valid SHALL rise the cycle after the final accepted beat, so latency from the last beat to out_valid is 1 cycle.
REQ-026 Throughout the OUTPUT state, out_valid SHALL remain high and out_data SHALL remain stable until out_ready is high.
REQ-027 done SHALL pulse for exactly one cycle, the cycle after the handshake, coincident with the return to IDLE.
REQ-028 start SHALL be ignored outside IDLE, and in_valid SHALL be ignored outside ACCUM.
REQ-029 start may be asserted in the cycle done is high; the block SHALL then enter ACCUM, with no dead cycles beyond IDLE.
REQ-030 With NUM_INPUTS=1, the first accepted beat SHALL also be the final beat.

Reset
REQ-031 reset SHALL take priority over all other inputs, including mid-ACCUM or mid-OUTPUT, and the block SHALL leave its reset values on the first clock edge after reset deasserts.
REQ-032 While reset is high, the block SHALL hold the following values:
- state=IDLE;
- accumulators and beat counter = 0;
- out_data=0;
- out_valid, in_ready, busy and done = 0.
Any partial result is discarded and no done pulse is issued.

Structure
REQ-033 The shared package dense_pkg SHALL hold the FSM state encoding, a sat/shift helper function and accumulator-width constants.
REQ-034 One sub-module, dense_lane (a single signed MAC with its accumulator), SHALL be instantiated NUM_OUTPUTS times via generate.
REQ-035 dense_layer SHALL own the FSM, beat counter, bias add, saturation, ReLU and output register.

Verification
REQ-036 The bench SHALL cover a basic vector (N=16, Q=8):
- stimulus: in_data=256 x4, lane0 weight=512, bias0=128, lane1 weight=-256, bias1=0, RELU_EN=0;
- response: out lane0=2176, lane1=-1024, out_valid 1 cycle after beat 4.
REQ-037 The bench SHALL cover ReLU:
- stimulus: the same vector with RELU_EN=1;
- response: lane1=0, lane0=2176.
REQ-038 The bench SHALL cover saturation:
- stimulus: in_data=32767 and weights=32767 x4; then in_data=-32768 with weight=32767, RELU_EN=0;
- response: 32767 for the first case, -32768 for the second.
REQ-039 The bench SHALL cover handshakes:
- in_valid toggling 1-0-1-0 -> still 4 beats consumed, result identical;
- out_ready low 5 cycles -> out_valid and out_data stable, done only after the acceptance.
REQ-040 The bench SHALL cover reset mid-ACCUM:
- stimulus: reset after 2 beats, then a fresh run;
- response: busy=0, no done pulse; the fresh run's result is unaffected by the aborted beats.
REQ-041 The bench SHALL cover back-to-back runs:
- stimulus: start asserted with done;
- response: the second run accepts its first beat the next cycle and its results are correct.
